// File: rtl/data_memory_pl.sv
// Line-oriented backing memory with fixed-latency request/ack handshake,
// per-byte write masking and out-of-range error reporting.
module data_memory_pl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int ADDR_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LINE_W/8-1:0] wmask_i,
  input  logic [LINE_W-1:0]   data_i,
  output logic                ready_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [LINE_W-1:0]   data_o
);

  localparam int BYTES = LINE_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic exec;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] in_line;
  logic              in_oor;
  logic [IDX_W-1:0]  in_idx;

  logic [IDX_W-1:0]  lat_idx;
  logic              lat_oor;
  logic              lat_we;
  logic [BYTES-1:0]  lat_mask;
  logic [LINE_W-1:0] lat_data;

  logic [IDX_W-1:0]  op_idx;
  logic              op_oor;
  logic              op_we;
  logic [BYTES-1:0]  op_mask;
  logic [LINE_W-1:0] op_data;
  logic [LINE_W-1:0] merged;

  always_comb begin
    in_line = addr_i >> OFF_W;
    in_oor  = in_line >= ADDR_W'(DEPTH);
    in_idx  = in_line[IDX_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // With LATENCY=1 the operation executes on the accepting edge and never enters BUSY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    exec       = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (LATENCY == 1) begin
            exec = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == CW'(LATENCY - 1)) begin
          exec       = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_idx  <= '0;
      lat_oor  <= 1'b0;
      lat_we   <= 1'b0;
      lat_mask <= '0;
      lat_data <= '0;
    end else if (req_i && state == IDLE) begin
      lat_idx  <= in_idx;
      lat_oor  <= in_oor;
      lat_we   <= we_i;
      lat_mask <= wmask_i;
      lat_data <= data_i;
    end
  end

  // Executing from IDLE only happens when LATENCY=1, so the live inputs are used.
  always_comb begin
    if (state == IDLE) begin
      op_idx  = in_idx;
      op_oor  = in_oor;
      op_we   = we_i;
      op_mask = wmask_i;
      op_data = data_i;
    end else begin
      op_idx  = lat_idx;
      op_oor  = lat_oor;
      op_we   = lat_we;
      op_mask = lat_mask;
      op_data = lat_data;
    end
  end

  always_comb begin
    merged = mem[op_idx];
    for (int k = 0; k < BYTES; k++) begin
      if (op_we && op_mask[k]) begin
        merged[8*k +: 8] = op_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (exec && op_we && !op_oor && !rst_i) begin
      mem[op_idx] <= merged;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= exec;
      err_o <= exec && op_oor;
      if (exec) begin
        data_o <= op_oor ? '0 : merged;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_pl.sv
// Directed self-checking bench for data_memory_pl (LATENCY=10 and LATENCY=1 instances).
module tb_data_memory_pl;

  logic         clk, rst;
  logic         req, we;
  logic [31:0]  addr;
  logic [31:0]  mask;
  logic [255:0] wdata;
  logic         ready, ack, err;
  logic [255:0] rdata;

  logic         req1, we1;
  logic [31:0]  addr1;
  logic [31:0]  mask1;
  logic [255:0] wdata1;
  logic         ready1, ack1, err1;
  logic [255:0] rdata1;

  int checks = 0;
  int passes = 0;

  localparam logic [255:0] PAT_A5  = {32{8'hA5}};
  localparam logic [255:0] PAT_L0  = {8{32'h0BAD_F00D}};
  localparam logic [255:0] PAT_D1  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_D2  = {8{32'h0123_4567}};
  localparam logic [255:0] PAT_OLD = {16{16'h5A5A}};
  localparam logic [255:0] PAT_X1  = {4{64'hCAFE_0000_1234_5678}};

  data_memory_pl #(.LINE_W(256), .DEPTH(512), .LATENCY(10), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wmask_i(mask), .data_i(wdata), .ready_o(ready), .ack_o(ack),
    .err_o(err), .data_o(rdata)
  );

  data_memory_pl #(.LINE_W(256), .DEPTH(512), .LATENCY(1), .ADDR_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wmask_i(mask1), .data_i(wdata1), .ready_o(ready1), .ack_o(ack1),
    .err_o(err1), .data_o(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and reports what the DUT did; inputs are scrambled after acceptance.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] m,
                         input logic [255:0] d, output int lat, output logic busy_ok,
                         output logic one_cycle, output logic [255:0] dout, output logic eout);
    lat = -1; busy_ok = 1'b1; one_cycle = 1'b0; dout = 'x; eout = 1'bx;
    we = w; addr = a; mask = m; wdata = d; req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req = 1'b0; wdata = ~d; addr = a ^ 32'h20; mask = ~m;
      end
      if (ack === 1'b1) begin
        lat = c; dout = rdata; eout = err;
        break;
      end
      if (ready !== 1'b0) busy_ok = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      one_cycle = (ack === 1'b0);
    end
  endtask

  task automatic test_reset();
    logic idle_ok;
    rst = 1'b1;
    #3;
    checks++; if ({ready, ack, err} !== 3'b100) $display("[TB] FAIL reset_flags got=%b want=100", {ready, ack, err}); else passes++;
    checks++; if (rdata !== '0) $display("[TB] FAIL reset_data got=%h want=0", rdata); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || ack !== 1'b0 || err !== 1'b0 || rdata !== '0 || ready1 !== 1'b1 || ack1 !== 1'b0)
        idle_ok = 1'b0;
    end
    checks++; if (idle_ok !== 1'b1) $display("[TB] FAIL idle_20 got=%b want=1", idle_ok); else passes++;
  endtask

  task automatic test_full_write_read();
    int lat; logic bz, oc, e; logic [255:0] d;
    run_txn(1'b1, 32'h40, 32'hFFFF_FFFF, PAT_A5, lat, bz, oc, d, e);
    checks++; if (lat !== 10) $display("[TB] FAIL wr_latency got=%0d want=10", lat); else passes++;
    checks++; if (bz !== 1'b1) $display("[TB] FAIL wr_busy_ready got=%b want=1", bz); else passes++;
    checks++; if (oc !== 1'b1) $display("[TB] FAIL wr_ack_width got=%b want=1", oc); else passes++;
    checks++; if (d !== PAT_A5) $display("[TB] FAIL wr_data got=%h want=%h", d, PAT_A5); else passes++;
    checks++; if (e !== 1'b0) $display("[TB] FAIL wr_err got=%b want=0", e); else passes++;
    run_txn(1'b0, 32'h40, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (lat !== 10) $display("[TB] FAIL rd_latency got=%0d want=10", lat); else passes++;
    checks++; if (bz !== 1'b1 || oc !== 1'b1) $display("[TB] FAIL rd_handshake got=%b%b want=11", bz, oc); else passes++;
    checks++; if (d !== PAT_A5) $display("[TB] FAIL rd_data got=%h want=%h", d, PAT_A5); else passes++;
    checks++; if (rdata !== PAT_A5) $display("[TB] FAIL rd_hold got=%h want=%h", rdata, PAT_A5); else passes++;
  endtask

  task automatic test_byte_mask();
    int lat; logic bz, oc, e; logic [255:0] d;
    run_txn(1'b1, 32'h60, 32'hFFFF_FFFF, '0, lat, bz, oc, d, e);
    run_txn(1'b1, 32'h60, 32'h0000_0001, {256{1'b1}}, lat, bz, oc, d, e);
    checks++; if (d !== 256'hFF) $display("[TB] FAIL mask_low got=%h want=%h", d, 256'hFF); else passes++;
    run_txn(1'b0, 32'h7F, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== 256'hFF) $display("[TB] FAIL mask_unaligned_rd got=%h want=%h", d, 256'hFF); else passes++;
    run_txn(1'b1, 32'h60, 32'h8000_0000, {32{8'h11}}, lat, bz, oc, d, e);
    checks++; if (d !== {8'h11, 240'h0, 8'hFF}) $display("[TB] FAIL mask_high got=%h want=%h", d, {8'h11, 240'h0, 8'hFF}); else passes++;
    run_txn(1'b1, 32'h60, 32'h0, {256{1'b1}}, lat, bz, oc, d, e);
    checks++; if (d !== {8'h11, 240'h0, 8'hFF}) $display("[TB] FAIL mask_zero got=%h want=%h", d, {8'h11, 240'h0, 8'hFF}); else passes++;
  endtask

  task automatic test_out_of_range();
    int lat; logic bz, oc, e; logic [255:0] d;
    run_txn(1'b1, 32'h0, 32'hFFFF_FFFF, PAT_L0, lat, bz, oc, d, e);
    run_txn(1'b0, 32'h4000, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (lat !== 10) $display("[TB] FAIL oor_latency got=%0d want=10", lat); else passes++;
    checks++; if (e !== 1'b1) $display("[TB] FAIL oor_err got=%b want=1", e); else passes++;
    checks++; if (d !== '0) $display("[TB] FAIL oor_data got=%h want=0", d); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL oor_err_clear got=%b want=0", err); else passes++;
    run_txn(1'b1, 32'h4000, 32'hFFFF_FFFF, {256{1'b1}}, lat, bz, oc, d, e);
    run_txn(1'b0, 32'h0, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== PAT_L0 || e !== 1'b0) $display("[TB] FAIL oor_no_corrupt got=%h err=%b want=%h err=0", d, e, PAT_L0); else passes++;
  endtask

  task automatic test_busy_ignore();
    int acks, first; logic [255:0] d1; int lat; logic bz, oc, e; logic [255:0] d;
    acks = 0; first = -1; d1 = 'x;
    we = 1'b0; addr = 32'h40; mask = '0; wdata = '0; req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      if (c == 3) begin req = 1'b1; we = 1'b1; mask = 32'hFFFF_FFFF; wdata = '0; end
      if (c == 4) req = 1'b0;
      if (ack === 1'b1) begin
        acks++;
        if (first < 0) begin first = c; d1 = rdata; end
      end
    end
    checks++; if (acks !== 1 || first !== 10) $display("[TB] FAIL busy_acks got=%0d@%0d want=1@10", acks, first); else passes++;
    checks++; if (d1 !== PAT_A5) $display("[TB] FAIL busy_data got=%h want=%h", d1, PAT_A5); else passes++;
    run_txn(1'b0, 32'h40, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== PAT_A5) $display("[TB] FAIL busy_no_write got=%h want=%h", d, PAT_A5); else passes++;
  endtask

  task automatic test_back_to_back();
    int acks, a1, a2; logic [255:0] v1, v2; int lat; logic bz, oc, e; logic [255:0] d;
    acks = 0; a1 = -1; a2 = -1; v1 = 'x; v2 = 'x;
    we = 1'b1; addr = 32'hA0; mask = 32'hFFFF_FFFF; wdata = PAT_D1; req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin addr = 32'hC0; wdata = PAT_D2; end
      if (c == 11) req = 1'b0;
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) begin a1 = c; v1 = rdata; end
        else if (acks == 2) begin a2 = c; v2 = rdata; end
      end
    end
    checks++; if (acks !== 2 || a1 !== 10 || a2 !== 20) $display("[TB] FAIL b2b_timing got=%0d acks @%0d,%0d want=2 @10,20", acks, a1, a2); else passes++;
    checks++; if (v1 !== PAT_D1) $display("[TB] FAIL b2b_first_data got=%h want=%h", v1, PAT_D1); else passes++;
    checks++; if (v2 !== PAT_D2) $display("[TB] FAIL b2b_second_data got=%h want=%h", v2, PAT_D2); else passes++;
    run_txn(1'b0, 32'hA0, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== PAT_D1) $display("[TB] FAIL b2b_line5 got=%h want=%h", d, PAT_D1); else passes++;
    run_txn(1'b0, 32'hC0, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== PAT_D2) $display("[TB] FAIL b2b_line6 got=%h want=%h", d, PAT_D2); else passes++;
  endtask

  task automatic test_reset_mid_op();
    int acks; int lat; logic bz, oc, e; logic [255:0] d;
    run_txn(1'b1, 32'hE0, 32'hFFFF_FFFF, PAT_OLD, lat, bz, oc, d, e);
    we = 1'b1; addr = 32'hE0; mask = 32'hFFFF_FFFF; wdata = '0; req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if ({ready, ack, err} !== 3'b100 || rdata !== '0) $display("[TB] FAIL midrst_outputs got=%b data=%h want=100 data=0", {ready, ack, err}, rdata); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) acks++;
    end
    checks++; if (acks !== 0) $display("[TB] FAIL midrst_no_ack got=%0d want=0", acks); else passes++;
    run_txn(1'b0, 32'hE0, 32'h0, '0, lat, bz, oc, d, e);
    checks++; if (d !== PAT_OLD) $display("[TB] FAIL midrst_old_data got=%h want=%h", d, PAT_OLD); else passes++;
  endtask

  task automatic test_latency_one();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; mask1 = 32'hFFFF_FFFF; wdata1 = PAT_X1;
    checks++; if (ready1 !== 1'b1) $display("[TB] FAIL lat1_ready_req got=%b want=1", ready1); else passes++;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b1 || ready1 !== 1'b1 || err1 !== 1'b0) $display("[TB] FAIL lat1_wr_ack got=%b%b%b want=110", ack1, ready1, err1); else passes++;
    checks++; if (rdata1 !== PAT_X1) $display("[TB] FAIL lat1_wr_data got=%h want=%h", rdata1, PAT_X1); else passes++;
    req1 = 1'b0; wdata1 = '0;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0) $display("[TB] FAIL lat1_ack_width got=%b want=0", ack1); else passes++;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h3F;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b1 || rdata1 !== PAT_X1) $display("[TB] FAIL lat1_rd got=%b %h want=1 %h", ack1, rdata1, PAT_X1); else passes++;
    addr1 = 32'h4000;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== '0) $display("[TB] FAIL lat1_oor got=%b%b %h want=11 0", ack1, err1, rdata1); else passes++;
    req1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0 || err1 !== 1'b0) $display("[TB] FAIL lat1_idle got=%b%b want=00", ack1, err1); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; mask = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; mask1 = '0; wdata1 = '0;
    test_reset();
    test_full_write_read();
    test_byte_mask();
    test_out_of_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_latency_one();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
